// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Read data returned to the owner when the memory never acknowledges.
  localparam logic [31:0] POISON = 32'hDEADBEEF;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Counts wait cycles of an outstanding memory command; flags expiry on the last allowed cycle.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic CLR,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Every wait period is entered from a non-waiting state, so clearing while idle
  // gives a fresh count on each entry.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (!ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = active & ~ack & (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory; data wins ties, 3-cycle minimum latency.
// Build with ARB_TIMEOUT_EN to add the wait watchdog and sticky err; otherwise mem_ack is awaited forever.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err
);

  localparam logic [DATA_W-1:0] POISON_W = DATA_W'(POISON);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t state, state_nxt;
  logic       owner_d;
  logic       timeout;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req) begin
          state_nxt = WAIT_D;
        end else if (i_req) begin
          state_nxt = WAIT_I;
        end
      end
      WAIT_I, WAIT_D: begin
        if (mem_ack || timeout) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command fields are latched once when leaving IDLE and held for the whole wait.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      owner_d   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE) begin
      if (d_req) begin
        owner_d   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (i_req) begin
        owner_d   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (state == WAIT_I) begin
        if (mem_ack) begin
          i_rdata <= mem_rdata;
        end else if (timeout) begin
          i_rdata <= POISON_W;
        end
      end
      // A write acknowledgement carries no useful data, so d_rdata keeps its last read.
      if (state == WAIT_D) begin
        if (mem_ack) begin
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end else if (timeout) begin
          d_rdata <= POISON_W;
        end
      end
    end
  end

  assign mem_req = (state == WAIT_I) || (state == WAIT_D);
  assign i_done  = (state == DONE) && !owner_d;
  assign d_done  = (state == DONE) && owner_d;
  assign stall_f = i_req & ~i_done;
  assign stall_m = d_req & ~d_done;

`ifdef ARB_TIMEOUT_EN
  logic err_q;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK     (CLK),
    .CLR     (CLR),
    .active  (mem_req),
    .ack     (mem_ack),
    .expired (timeout)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          CLR = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall_f, stall_m, err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .CLR(CLR),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Memory image seen by the memory device, and the requesters' own view of memory.
  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];

  // Memory device: acks after a fixed or random delay; may emit stray acks while idle.
  int ack_delay = 0;
  bit spurious_en = 1'b0;
  initial begin
    int left;
    bit busy;
    left = 0;
    busy = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge CLK);
      #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (!mem_req) begin
        busy = 1'b0;
        if (spurious_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          left = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
        end
        if (left == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_arr[idx(mem_addr)];
          if (mem_we) mem_arr[idx(mem_addr)] = mem_wdata;
        end else begin
          left--;
        end
      end
    end
  end

  // Reference model: one transaction at a time, completion one cycle after the
  // ack (or after TO unacknowledged wait cycles), read data from ref_mem.
  bit          mon_en = 1'b0;
  bit          i_got = 1'b0, d_got = 1'b0;
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_d_req = 1'b0, p_to = 1'b0;
  logic        owner_d = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [31:0] exp_i_rdata = '0, exp_d_rdata = '0;
  logic        exp_err = 1'b0;
  int          wcnt = 0;

  always @(negedge CLK) begin
    bit fin, exp_i, exp_d;
    if (!CLR) begin
      p_req = 1'b0; p_ack = 1'b0; p_to = 1'b0; p_d_req = 1'b0;
      exp_i_rdata = '0; exp_d_rdata = '0; exp_err = 1'b0; wcnt = 0;
    end else if (mon_en) begin
      fin   = p_req && (p_ack || p_to);
      exp_i = fin && !owner_d;
      exp_d = fin && owner_d;
      check("i_done", i_done, exp_i);
      check("d_done", d_done, exp_d);
      if (fin) check("mem_req_release", mem_req, 1'b0);
      if (exp_i) begin
        exp_i_rdata = p_to ? POISON : ref_mem[idx(i_addr)];
      end
      if (exp_d) begin
        if (p_to) exp_d_rdata = POISON;
        else if (d_we) ref_mem[idx(d_addr)] = d_wdata;
        else exp_d_rdata = ref_mem[idx(d_addr)];
      end
      if (p_to) exp_err = 1'b1;
      if (i_done) i_got = 1'b1;
      if (d_done) d_got = 1'b1;
      check("i_rdata", i_rdata, exp_i_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      check("stall_f", stall_f, i_req && !i_done);
      check("stall_m", stall_m, d_req && !d_done);
      check("err", err, exp_err);
      if (mem_req && !p_req) begin
        owner_d = p_d_req;
        wcnt = 0;
        if (owner_d) begin
          check("cmd_addr_d", mem_addr, d_addr);
          check("cmd_we_d", mem_we, d_we);
          if (d_we) check("cmd_wdata_d", mem_wdata, d_wdata);
        end else begin
          check("cmd_addr_i", mem_addr, i_addr);
          check("cmd_we_i", mem_we, 1'b0);
        end
      end else if (mem_req && p_req) begin
        check("hold_addr", mem_addr, p_addr);
        check("hold_we", mem_we, p_we);
        check("hold_wdata", mem_wdata, p_wdata);
      end
      if (mem_req && !mem_ack) wcnt++;
`ifdef ARB_TIMEOUT_EN
      p_to = mem_req && !mem_ack && (wcnt == TO);
`else
      p_to = 1'b0;
`endif
      p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
      p_addr = mem_addr; p_wdata = mem_wdata; p_d_req = d_req;
    end
  end

  // Random requesters: hold each request until its done pulse, then pick anew.
  bit rnd_en = 1'b0;
  initial forever begin
    tick();
    if (rnd_en) begin
      if (!i_req || i_got) begin
        i_got = 1'b0;
        i_req = ($urandom_range(0, 2) != 0);
        if (i_req) i_addr = rand_addr();
      end
      if (!d_req || d_got) begin
        d_got = 1'b0;
        d_req = ($urandom_range(0, 2) != 0);
        if (d_req) begin
          d_we = 1'($urandom_range(0, 1));
          d_addr = rand_addr();
          d_wdata = $urandom;
        end
      end
    end else begin
      if (i_req && i_got) begin i_req = 1'b0; i_got = 1'b0; end
      if (d_req && d_got) begin d_req = 1'b0; d_got = 1'b0; end
    end
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    bit drained;
    for (int k = 0; k < 256; k++) begin
      mem_arr[k] = $urandom;
      ref_mem[k] = mem_arr[k];
    end
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_i_done", i_done, 1'b0);
    check("rst_d_done", d_done, 1'b0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_err", err, 1'b0);
    #11;
    CLR = 1'b1;
    mon_en = 1'b1;

    // Fetch only, immediate ack.
    mem_arr[idx(32'h40)] = 32'h8C090020;
    ref_mem[idx(32'h40)] = 32'h8C090020;
    ack_delay = 0;
    tick(); i_req = 1'b1; i_addr = 32'h40;
    @(negedge CLK); check("f_c0_mem_req", mem_req, 1'b0); check("f_c0_stall_f", stall_f, 1'b1);
    tick(); @(negedge CLK);
    check("f_c1_mem_req", mem_req, 1'b1); check("f_c1_we", mem_we, 1'b0);
    check("f_c1_addr", mem_addr, 32'h40); check("f_c1_stall_f", stall_f, 1'b1);
    tick(); @(negedge CLK);
    check("f_c2_i_done", i_done, 1'b1); check("f_c2_i_rdata", i_rdata, 32'h8C090020);
    check("f_c2_stall_f", stall_f, 1'b0);
    tick(); i_req = 1'b0;

    // Simultaneous fetch and data write: data served first.
    tick(); i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h5;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (c < 5) check("sim_stall_f", stall_f, 1'b1);
      if (c == 1) begin
        check("sim_c1_we", mem_we, 1'b1); check("sim_c1_addr", mem_addr, 32'h100);
        check("sim_c1_wdata", mem_wdata, 32'h5);
      end
      if (c == 2) check("sim_c2_d_done", d_done, 1'b1);
      if (c == 4) begin
        check("sim_c4_addr", mem_addr, 32'h44); check("sim_c4_we", mem_we, 1'b0);
      end
      if (c == 5) check("sim_c5_i_done", i_done, 1'b1);
      tick();
      if (c == 2) d_req = 1'b0;
      if (c == 5) i_req = 1'b0;
    end

    // Slow memory: ack in the fifth mem_req cycle.
    ack_delay = 4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (c >= 1 && c <= 5) begin
        check("slow_mem_req", mem_req, 1'b1); check("slow_addr", mem_addr, 32'h104);
      end
      if (c == 6) begin
        check("slow_d_done", d_done, 1'b1); check("slow_d_rdata", d_rdata, ref_mem[idx(32'h104)]);
      end
      if (c == 7) check("slow_d_done_once", d_done, 1'b0);
      tick();
      if (c == 6) d_req = 1'b0;
    end

    // Reset in the middle of a data wait.
    ack_delay = 1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    repeat (3) tick();
    @(negedge CLK); check("rstmid_waiting", mem_req, 1'b1);
    #2 CLR = 1'b0;
    #1;
    check("rstmid_mem_req", mem_req, 1'b0); check("rstmid_addr", mem_addr, 32'h0);
    d_req = 1'b0;
    repeat (2) begin
      @(negedge CLK); check("rstmid_no_done", d_done, 1'b0);
    end
    #2 CLR = 1'b1;
    ack_delay = 0;
    tick(); i_req = 1'b1; i_addr = 32'h8;
    tick(); @(negedge CLK); check("post_rst_mem_req", mem_req, 1'b1); check("post_rst_addr", mem_addr, 32'h8);
    tick(); @(negedge CLK); check("post_rst_i_done", i_done, 1'b1);
    check("post_rst_i_rdata", i_rdata, ref_mem[idx(32'h8)]);
    tick(); i_req = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: poison data and sticky err.
    ack_delay = 1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      if (c >= 1 && c <= 16) check("to_mem_req", mem_req, 1'b1);
      if (c == 17) begin
        check("to_d_done", d_done, 1'b1); check("to_d_rdata", d_rdata, 32'hDEADBEEF);
        check("to_err", err, 1'b1);
      end
      tick();
    end
    d_req = 1'b0;
    ack_delay = 0;
    tick(); i_req = 1'b1; i_addr = 32'h10;
    tick(); tick(); @(negedge CLK);
    check("to_next_i_done", i_done, 1'b1); check("to_err_sticky", err, 1'b1);
    tick(); i_req = 1'b0;
`endif

    // Randomized traffic with random ack delays and stray acks.
    i_got = 1'b0; d_got = 1'b0;
    ack_delay = -1;
    spurious_en = 1'b1;
    rnd_en = 1'b1;
    repeat (3000) tick();
    rnd_en = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 200 && !drained; c++) begin
      tick();
      drained = !i_req && !d_req && !mem_req;
    end
    check("drain", drained, 1'b1);
    spurious_en = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
